exe_stage: RTL and testbench

- Execute pipeline stage between decode (ID) and memory (MEM).
- Registers ID's operands behind a valid/ready handshake and drives them into the combinational alu.
- Hosts a multi-cycle iterative divider for div.w/mod.w/div.wu/mod.wu, selects the stage result, and exports a forwarding/interlock view back to ID.

---
 rtl/cpu_defs.sv | 35 +++
 rtl/exe_stage_alu.sv | 45 ++++
 rtl/exe_stage_div_unit.sv | 129 ++++++++++++
 rtl/exe_stage.sv | 137 +++++++++++++
 tb/tb_exe_stage.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_defs.sv
// Shared definitions for the execute stage: datapath width, alu one-hot
// control layout, divider state encoding and divider constants.
package cpu_defs;

    // Datapath width used by the core (the only supported value).
    localparam int CPU_XLEN = 32;

    // alu one-hot control word and the meaning of each bit.
    localparam int ALU_OP_W = 14;
    localparam int ALU_ADD  = 0;
    localparam int ALU_SUB  = 1;
    localparam int ALU_SLT  = 2;
    localparam int ALU_SLTU = 3;
    localparam int ALU_AND  = 4;
    localparam int ALU_NOR  = 5;
    localparam int ALU_OR   = 6;
    localparam int ALU_XOR  = 7;
    localparam int ALU_SLL  = 8;
    localparam int ALU_SRL  = 9;
    localparam int ALU_SRA  = 10;
    localparam int ALU_LUI  = 11;   // passes src2 through (immediate pre-shifted by ID)
    localparam int ALU_ANDN = 12;
    localparam int ALU_ORN  = 13;

    // Iterative divider states.
    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_RUN  = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    // Quotient returned for a division by zero (signed and unsigned).
    localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;

endpackage

// File: rtl/exe_stage_alu.sv
// Combinational alu driven by a one-hot control word.
// Ports: i_op (one-hot op select), i_a/i_b (operands), o_y (result).
// With no op bit set the result is zero.
module alu
    import cpu_defs::*;
#(
    parameter int W = 32
) (
    input  logic [ALU_OP_W-1:0] i_op,
    input  logic [W-1:0]        i_a,
    input  logic [W-1:0]        i_b,
    output logic [W-1:0]        o_y
);

    localparam int SHW = $clog2(W);

    logic [W-1:0]   w_add;
    logic [W-1:0]   w_sub;
    logic           w_slt;
    logic           w_sltu;
    logic [SHW-1:0] w_sa;

    assign w_add  = i_a + i_b;
    assign w_sub  = i_a - i_b;
    assign w_slt  = $signed(i_a) < $signed(i_b);
    assign w_sltu = i_a < i_b;
    assign w_sa   = i_b[SHW-1:0];

    // One-hot control: each term is masked by its own select bit and OR-ed.
    assign o_y = ({W{i_op[ALU_ADD]}}  & w_add)
               | ({W{i_op[ALU_SUB]}}  & w_sub)
               | ({W{i_op[ALU_SLT]}}  & {{(W-1){1'b0}}, w_slt})
               | ({W{i_op[ALU_SLTU]}} & {{(W-1){1'b0}}, w_sltu})
               | ({W{i_op[ALU_AND]}}  & (i_a & i_b))
               | ({W{i_op[ALU_NOR]}}  & ~(i_a | i_b))
               | ({W{i_op[ALU_OR]}}   & (i_a | i_b))
               | ({W{i_op[ALU_XOR]}}  & (i_a ^ i_b))
               | ({W{i_op[ALU_SLL]}}  & (i_a << w_sa))
               | ({W{i_op[ALU_SRL]}}  & (i_a >> w_sa))
               | ({W{i_op[ALU_SRA]}}  & W'($signed(i_a) >>> w_sa))
               | ({W{i_op[ALU_LUI]}}  & i_b)
               | ({W{i_op[ALU_ANDN]}} & (i_a & ~i_b))
               | ({W{i_op[ALU_ORN]}}  & (i_a | ~i_b));

endmodule

// File: rtl/exe_stage_div_unit.sv
// Iterative restoring divider, one quotient bit per cycle.
// Ports: clk/rst_n; i_start loads operands (IDLE or DONE), i_signed selects
// signed semantics, i_abort returns to IDLE, i_ack releases a DONE result;
// o_done flags a held result in o_quotient/o_remainder.
// Timing: load at edge N, ITER iterations on edges N+1..N+ITER, sign
// fix-up on edge N+ITER+1 which also enters DONE.
module div_unit
    import cpu_defs::*;
#(
    parameter int W    = 32,
    parameter int ITER = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_start,
    input  logic         i_signed,
    input  logic         i_abort,
    input  logic         i_ack,
    input  logic [W-1:0] i_dividend,
    input  logic [W-1:0] i_divisor,
    output logic         o_done,
    output logic [W-1:0] o_quotient,
    output logic [W-1:0] o_remainder
);

    localparam logic [5:0] LAST = 6'(ITER);

    div_state_e   r_state;
    div_state_e   w_next;
    logic [5:0]   r_cnt;
    logic [W-1:0] r_quo;      // dividend bits shifting out, quotient bits shifting in
    logic [W-1:0] r_rem;
    logic [W-1:0] r_dvs;
    logic         r_neg_q;
    logic         r_neg_r;
    logic         r_dvz;

    logic         w_a_neg;
    logic         w_b_neg;
    logic [W-1:0] w_a_mag;
    logic [W-1:0] w_b_mag;
    logic         w_load;
    logic [W:0]   w_shift;
    logic         w_ge;
    logic [W-1:0] w_sub;

    assign w_a_neg = i_signed & i_dividend[W-1];
    assign w_b_neg = i_signed & i_divisor[W-1];
    assign w_a_mag = w_a_neg ? -i_dividend : i_dividend;
    assign w_b_mag = w_b_neg ? -i_divisor  : i_divisor;
    assign w_load  = i_start & ~i_abort & ((r_state == DIV_IDLE) | (r_state == DIV_DONE));

    // Trial subtraction; when it succeeds the partial remainder is below the
    // divisor, so the truncated W-bit difference is exact.
    assign w_shift = {r_rem, r_quo[W-1]};
    assign w_ge    = w_shift >= {1'b0, r_dvs};
    assign w_sub   = w_shift[W-1:0] - r_dvs;

    assign o_done      = (r_state == DIV_DONE);
    assign o_quotient  = r_quo;
    assign o_remainder = r_rem;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= DIV_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; abort wins over everything.
    always_comb begin
        w_next = r_state;
        if (i_abort) begin
            w_next = DIV_IDLE;
        end else begin
            case (r_state)
                DIV_IDLE: w_next = i_start ? DIV_RUN : DIV_IDLE;
                DIV_RUN:  w_next = (r_cnt == LAST) ? DIV_DONE : DIV_RUN;
                DIV_DONE: begin
                    if (i_start) begin
                        w_next = DIV_RUN;
                    end else if (i_ack) begin
                        w_next = DIV_IDLE;
                    end else begin
                        w_next = DIV_DONE;
                    end
                end
                default:  w_next = DIV_IDLE;
            endcase
        end
    end

    // Datapath: operand load, shift-subtract iterations, final sign fix-up.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= 6'd0;
            r_quo   <= '0;
            r_rem   <= '0;
            r_dvs   <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_dvz   <= 1'b0;
        end else if (w_load) begin
            r_cnt   <= 6'd0;
            r_quo   <= w_a_mag;
            r_rem   <= '0;
            r_dvs   <= w_b_mag;
            r_neg_q <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
            r_dvz   <= (i_divisor == '0);
        end else if ((r_state == DIV_RUN) && !i_abort) begin
            if (r_cnt != LAST) begin
                r_cnt <= r_cnt + 6'd1;
                r_quo <= {r_quo[W-2:0], w_ge};
                r_rem <= w_ge ? w_sub : w_shift[W-1:0];
            end else begin
                // Divide by zero leaves |dividend| in the remainder, so the
                // dividend-sign fix-up restores the original dividend.
                r_quo <= r_dvz ? W'(DIV_ZERO_Q) : (r_neg_q ? -r_quo : r_quo);
                r_rem <= r_neg_r ? -r_rem : r_rem;
            end
        end else begin
            r_cnt <= r_cnt;
        end
    end

endmodule

// File: rtl/exe_stage.sv
// Execute pipeline stage between ID and MEM.
// Ports: clk/rst_n/flush; ID side id_valid/id_ready and id_* fields;
// MEM side ex_valid/mem_ready and ex_pc/ex_result/ex_rd/ex_rf_we;
// forwarding view fwd_we/fwd_rd/fwd_data/fwd_busy back to ID.
// Non-divide ops complete the cycle after capture; divides occupy the
// stage for DIV_ITER+1 cycles in div_unit.
module exe_stage
    import cpu_defs::*;
#(
    parameter int XLEN     = 32,
    parameter int DIV_ITER = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                id_valid,
    output logic                id_ready,
    input  logic [XLEN-1:0]     id_pc,
    input  logic [ALU_OP_W-1:0] id_alu_op,
    input  logic [XLEN-1:0]     id_src1,
    input  logic [XLEN-1:0]     id_src2,
    input  logic                id_div_en,
    input  logic                id_div_signed,
    input  logic                id_div_mod,
    input  logic [4:0]          id_rd,
    input  logic                id_rf_we,
    output logic                ex_valid,
    input  logic                mem_ready,
    output logic [XLEN-1:0]     ex_pc,
    output logic [XLEN-1:0]     ex_result,
    output logic [4:0]          ex_rd,
    output logic                ex_rf_we,
    output logic                fwd_we,
    output logic [4:0]          fwd_rd,
    output logic [XLEN-1:0]     fwd_data,
    output logic                fwd_busy
);

    logic                r_valid;
    logic [XLEN-1:0]     r_pc;
    logic [ALU_OP_W-1:0] r_alu_op;
    logic [XLEN-1:0]     r_src1;
    logic [XLEN-1:0]     r_src2;
    logic                r_div;
    logic                r_div_mod;
    logic [4:0]          r_rd;
    logic                r_rf_we;

    logic                w_capture;
    logic                w_res_ready;
    logic                w_div_done;
    logic [XLEN-1:0]     w_alu_y;
    logic [XLEN-1:0]     w_quo;
    logic [XLEN-1:0]     w_rem;

    assign w_res_ready = ~r_div | w_div_done;
    assign id_ready    = ~r_valid | (w_res_ready & mem_ready);
    assign ex_valid    = r_valid & w_res_ready;
    assign w_capture   = id_valid & id_ready & ~flush;

    assign ex_pc     = r_pc;
    assign ex_rd     = r_rd;
    assign ex_rf_we  = r_valid & r_rf_we;
    assign ex_result = r_div ? (r_div_mod ? w_rem : w_quo) : w_alu_y;
    assign fwd_we    = r_valid & r_rf_we & (r_rd != 5'd0);
    assign fwd_rd    = r_rd;
    assign fwd_data  = ex_result;
    assign fwd_busy  = fwd_we & ~w_res_ready;

    // Stage valid: flush kills, capture fills, accepted/empty stage drains.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_capture) begin
            r_valid <= 1'b1;
        end else if (ex_valid & mem_ready) begin
            r_valid <= 1'b0;
        end else begin
            r_valid <= r_valid;
        end
    end

    // Pipe register for the instruction fields.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc      <= '0;
            r_alu_op  <= '0;
            r_src1    <= '0;
            r_src2    <= '0;
            r_div     <= 1'b0;
            r_div_mod <= 1'b0;
            r_rd      <= 5'd0;
            r_rf_we   <= 1'b0;
        end else if (w_capture) begin
            r_pc      <= id_pc;
            r_alu_op  <= id_alu_op;
            r_src1    <= id_src1;
            r_src2    <= id_src2;
            r_div     <= id_div_en;
            r_div_mod <= id_div_mod;
            r_rd      <= id_rd;
            r_rf_we   <= id_rf_we;
        end else begin
            r_pc      <= r_pc;
        end
    end

    alu #(
        .W (XLEN)
    ) u_alu (
        .i_op (r_alu_op),
        .i_a  (r_src1),
        .i_b  (r_src2),
        .o_y  (w_alu_y)
    );

    // The divider loads straight from the ID operands on the capture edge.
    div_unit #(
        .W    (XLEN),
        .ITER (DIV_ITER)
    ) u_div (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_start     (w_capture & id_div_en),
        .i_signed    (id_div_signed),
        .i_abort     (flush),
        .i_ack       (ex_valid & mem_ready),
        .i_dividend  (id_src1),
        .i_divisor   (id_src2),
        .o_done      (w_div_done),
        .o_quotient  (w_quo),
        .o_remainder (w_rem)
    );

endmodule

// File: tb/tb_exe_stage.sv
module tb_exe_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [13:0] id_alu_op;
    logic [31:0] id_src1;
    logic [31:0] id_src2;
    logic        id_div_en;
    logic        id_div_signed;
    logic        id_div_mod;
    logic [4:0]  id_rd;
    logic        id_rf_we;
    logic        ex_valid;
    logic        mem_ready;
    logic [31:0] ex_pc;
    logic [31:0] ex_result;
    logic [4:0]  ex_rd;
    logic        ex_rf_we;
    logic        fwd_we;
    logic [4:0]  fwd_rd;
    logic [31:0] fwd_data;
    logic        fwd_busy;

    int n_tests = 0;
    int n_fail  = 0;

    exe_stage #(.XLEN(32), .DIV_ITER(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (flush),
        .id_valid      (id_valid),
        .id_ready      (id_ready),
        .id_pc         (id_pc),
        .id_alu_op     (id_alu_op),
        .id_src1       (id_src1),
        .id_src2       (id_src2),
        .id_div_en     (id_div_en),
        .id_div_signed (id_div_signed),
        .id_div_mod    (id_div_mod),
        .id_rd         (id_rd),
        .id_rf_we      (id_rf_we),
        .ex_valid      (ex_valid),
        .mem_ready     (mem_ready),
        .ex_pc         (ex_pc),
        .ex_result     (ex_result),
        .ex_rd         (ex_rd),
        .ex_rf_we      (ex_rf_we),
        .fwd_we        (fwd_we),
        .fwd_rd        (fwd_rd),
        .fwd_data      (fwd_data),
        .fwd_busy      (fwd_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [13:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] pc, input logic [4:0] rd);
        id_valid = 1'b1; id_alu_op = op; id_src1 = a; id_src2 = b; id_pc = pc; id_rd = rd;
        id_rf_we = 1'b1; id_div_en = 1'b0; id_div_signed = 1'b0; id_div_mod = 1'b0;
    endtask

    // Issue one divide from an idle stage and check its full latency.
    task automatic do_div(input string tag, input logic sg, input logic md,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        int early;
        int nbusy;
        set_op(14'd0, a, b, 32'h0000_0400, 5'd7);
        id_div_en = 1'b1; id_div_signed = sg; id_div_mod = md;
        cyc();
        id_valid = 1'b0; id_div_en = 1'b0;
        #1;
        chk({tag, "_busy0"}, {31'd0, fwd_busy}, 32'd1);
        chk({tag, "_idrdy0"}, {31'd0, id_ready}, 32'd0);
        chk({tag, "_fwdwe"}, {31'd0, fwd_we}, 32'd1);
        early = 0; nbusy = 0;
        for (int i = 1; i <= 32; i++) begin
            cyc(); #1;
            if (ex_valid !== 1'b0) early++;
            if (fwd_busy === 1'b1 && id_ready === 1'b0) nbusy++;
        end
        chk({tag, "_no_early_valid"}, early, 32'd0);
        chk({tag, "_busy_cycles"}, nbusy, 32'd32);
        cyc(); #1;
        chk({tag, "_valid"}, {31'd0, ex_valid}, 32'd1);
        chk({tag, "_result"}, ex_result, exp);
        chk({tag, "_fwd_data"}, fwd_data, exp);
        chk({tag, "_busy_end"}, {31'd0, fwd_busy}, 32'd0);
        chk({tag, "_idrdy_end"}, {31'd0, id_ready}, 32'd1);
        cyc(); #1;
        chk({tag, "_drain"}, {31'd0, ex_valid}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        rst_n = 1'b0; flush = 1'b0; mem_ready = 1'b1;
        id_valid = 1'b0; id_pc = 32'd0; id_alu_op = 14'd0; id_src1 = 32'd0; id_src2 = 32'd0;
        id_div_en = 1'b0; id_div_signed = 1'b0; id_div_mod = 1'b0; id_rd = 5'd0; id_rf_we = 1'b0;
        #3;
        // Reset state
        chk("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
        chk("rst_ex_rf_we", {31'd0, ex_rf_we}, 32'd0);
        chk("rst_fwd_we", {31'd0, fwd_we}, 32'd0);
        chk("rst_fwd_busy", {31'd0, fwd_busy}, 32'd0);
        chk("rst_id_ready", {31'd0, id_ready}, 32'd1);
        chk("rst_ex_pc", ex_pc, 32'd0);
        chk("rst_ex_result", ex_result, 32'd0);
        chk("rst_ex_rd", {27'd0, ex_rd}, 32'd0);
        cyc(); cyc();
        rst_n = 1'b1;
        cyc();

        // ADD back-to-back
        set_op(14'h0001, 32'd5, 32'd7, 32'h0000_0100, 5'd3);
        #1;
        chk("add_idrdy_a", {31'd0, id_ready}, 32'd1);
        cyc();
        set_op(14'h0001, 32'hFFFF_FFFF, 32'd1, 32'h0000_0104, 5'd4);
        #1;
        chk("add1_valid", {31'd0, ex_valid}, 32'd1);
        chk("add1_result", ex_result, 32'd12);
        chk("add1_pc", ex_pc, 32'h0000_0100);
        chk("add1_rd", {27'd0, ex_rd}, 32'd3);
        chk("add1_rf_we", {31'd0, ex_rf_we}, 32'd1);
        chk("add1_fwd_we", {31'd0, fwd_we}, 32'd1);
        chk("add1_fwd_rd", {27'd0, fwd_rd}, 32'd3);
        chk("add1_fwd_busy", {31'd0, fwd_busy}, 32'd0);
        chk("add_idrdy_b", {31'd0, id_ready}, 32'd1);
        cyc();
        id_valid = 1'b0;
        #1;
        chk("add2_valid", {31'd0, ex_valid}, 32'd1);
        chk("add2_result", ex_result, 32'd0);
        chk("add2_pc", ex_pc, 32'h0000_0104);
        cyc(); #1;
        chk("add_drain", {31'd0, ex_valid}, 32'd0);

        // Signed divide -7 / 2 and -7 % 2
        do_div("sdiv_q", 1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        do_div("sdiv_r", 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);

        // Corner divides
        do_div("udz_q", 1'b0, 1'b0, 32'd100, 32'd0, 32'hFFFF_FFFF);
        do_div("udz_r", 1'b0, 1'b1, 32'd100, 32'd0, 32'd100);
        do_div("sdz_q", 1'b1, 1'b0, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF);
        do_div("sdz_r", 1'b1, 1'b1, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB);
        do_div("sovf_q", 1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        do_div("sovf_r", 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
        do_div("udiv_big", 1'b0, 1'b0, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC);

        // Backpressure
        mem_ready = 1'b0;
        set_op(14'h0001, 32'd3, 32'd4, 32'h0000_0200, 5'd6);
        cyc();
        set_op(14'h0001, 32'd1, 32'd1, 32'h0000_0204, 5'd6);
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (ex_valid === 1'b1 && ex_result === 32'd7 && ex_pc === 32'h0000_0200 && id_ready === 1'b0)
                seen++;
            cyc();
        end
        chk("bp_hold_cycles", seen, 32'd5);
        mem_ready = 1'b1;
        #1;
        chk("bp_release_idrdy", {31'd0, id_ready}, 32'd1);
        chk("bp_release_result", ex_result, 32'd7);
        cyc();
        id_valid = 1'b0;
        #1;
        chk("bp_next_valid", {31'd0, ex_valid}, 32'd1);
        chk("bp_next_result", ex_result, 32'd2);
        chk("bp_next_pc", ex_pc, 32'h0000_0204);
        cyc();

        // Flush mid-divide of 100/3
        set_op(14'd0, 32'd100, 32'd3, 32'h0000_0300, 5'd8);
        id_div_en = 1'b1;
        cyc();
        id_valid = 1'b0; id_div_en = 1'b0;
        for (int i = 0; i < 10; i++) cyc();
        flush = 1'b1;
        #1;
        chk("fl_busy_before", {31'd0, fwd_busy}, 32'd1);
        cyc();
        flush = 1'b0;
        #1;
        chk("fl_valid", {31'd0, ex_valid}, 32'd0);
        chk("fl_fwd_we", {31'd0, fwd_we}, 32'd0);
        chk("fl_fwd_busy", {31'd0, fwd_busy}, 32'd0);
        chk("fl_idrdy", {31'd0, id_ready}, 32'd1);
        set_op(14'h0002, 32'd9, 32'd4, 32'h0000_0304, 5'd9);
        cyc();
        id_valid = 1'b0;
        #1;
        chk("sub_valid", {31'd0, ex_valid}, 32'd1);
        chk("sub_result", ex_result, 32'd5);
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            cyc(); #1;
            if (ex_valid !== 1'b0) seen++;
        end
        chk("fl_no_residual", seen, 32'd0);

        // Flush drops a same-cycle capture
        set_op(14'h0001, 32'd1, 32'd2, 32'h0000_0308, 5'd10);
        flush = 1'b1;
        cyc();
        flush = 1'b0; id_valid = 1'b0;
        #1;
        chk("fl_capture_dropped", {31'd0, ex_valid}, 32'd0);

        // Async reset during RUN
        set_op(14'd0, 32'd100, 32'd7, 32'h0000_0500, 5'd11);
        id_div_en = 1'b1;
        cyc();
        id_valid = 1'b0; id_div_en = 1'b0;
        for (int i = 0; i < 5; i++) cyc();
        #1;
        chk("ar_busy_before", {31'd0, fwd_busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("ar_ex_valid", {31'd0, ex_valid}, 32'd0);
        chk("ar_fwd_we", {31'd0, fwd_we}, 32'd0);
        chk("ar_fwd_busy", {31'd0, fwd_busy}, 32'd0);
        chk("ar_idrdy", {31'd0, id_ready}, 32'd1);
        chk("ar_result", ex_result, 32'd0);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            cyc(); #1;
            if (ex_valid !== 1'b0) seen++;
        end
        chk("ar_no_residual", seen, 32'd0);
        do_div("ar_div", 1'b0, 1'b0, 32'd10, 32'd3, 32'd3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
